// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-axis geometry, the 640x480@60 preset and total/width helpers.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    localparam vga_axis_t VGA_640X480_60_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_axis_t VGA_640X480_60_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    function automatic int vga_total(vga_axis_t a);
        return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
    endfunction

    localparam int VGA_CNT_W = $clog2((vga_total(VGA_640X480_60_H) > vga_total(VGA_640X480_60_V)) ?
                                      vga_total(VGA_640X480_60_H) : vga_total(VGA_640X480_60_V));

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts active, front porch, sync, back porch, then wraps; wrap is a one-step pulse.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_axis_t AXIS  = VGA_640X480_60_H,
    parameter int        CNT_W = VGA_CNT_W
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output logic             in_active_o,
    output logic             in_sync_o
);

    localparam int TOTAL   = vga_total(AXIS);
    localparam int S_BEGIN = int'(AXIS.active) + int'(AXIS.fp);
    localparam int S_END   = S_BEGIN + int'(AXIS.sync);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        wrap_o      = step_i && (int'(count_q) == TOTAL - 1);
        count_d     = wrap_o ? '0 : count_q + CNT_W'(1);
        in_active_o = int'(count_q) < int'(AXIS.active);
        in_sync_o   = (int'(count_q) >= S_BEGIN) && (int'(count_q) < S_END);
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else if (step_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable divider, h/v counters and registered sync/blank/coordinate outputs.
// VGA_TIMING_LEAD_EN delays hs/vs/blank/strobes LEAD pixel periods behind the coordinate outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   CLK_DIV     = 4,
    parameter int   SCALE_SHIFT = 0,
    parameter int   COORD_W     = 10,
    parameter int   LEAD        = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    output logic               pix_ce,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic [COORD_W-1:0] current_x,
    output logic [COORD_W-1:0] current_y,
    output logic               fetch_valid,
    output logic               line_start,
    output logic               frame_start
);

    localparam vga_axis_t H_AXIS = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_axis_t V_AXIS = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int H_TOTAL = vga_total(H_AXIS);
    localparam int V_TOTAL = vga_total(V_AXIS);
    localparam int CNT_W   = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               ce;
    logic [CNT_W-1:0]   h_cnt, v_cnt;
    logic               h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
    logic               visible, h_first, v_first;
    logic               hs_d, vs_d;
    logic [COORD_W-1:0] x_d, y_d;
    logic               pix_ce_q, hs_q, vs_q, blank_q, fv_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic               ls_q, fs_q;
    logic               unused_v_wrap;

    always_comb begin
        ce      = en && (int'(div_q) == CLK_DIV - 1);
        div_d   = ce ? '0 : div_q + DIV_W'(1);
        visible = h_act && v_act;
        h_first = (h_cnt == '0);
        v_first = (v_cnt == '0);
        hs_d    = h_sync ? HS_POL : ~HS_POL;
        vs_d    = v_sync ? VS_POL : ~VS_POL;
        x_d     = visible ? COORD_W'(h_cnt >> SCALE_SHIFT) : '0;
        y_d     = v_act ? COORD_W'(v_cnt >> SCALE_SHIFT) : '0;
    end

    vga_axis_counter #(.AXIS(H_AXIS), .CNT_W(CNT_W)) u_h_cnt (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .step_i      (ce),
        .count_o     (h_cnt),
        .wrap_o      (h_wrap),
        .in_active_o (h_act),
        .in_sync_o   (h_sync)
    );

    vga_axis_counter #(.AXIS(V_AXIS), .CNT_W(CNT_W)) u_v_cnt (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .step_i      (h_wrap),
        .count_o     (v_cnt),
        .wrap_o      (v_wrap),
        .in_active_o (v_act),
        .in_sync_o   (v_sync)
    );

    assign unused_v_wrap = v_wrap;

    // Outputs sample the pre-increment (h,v) on ce, so they describe the pixel just counted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            blank_q  <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            fv_q     <= 1'b0;
        end else begin
            pix_ce_q <= ce;
            if (en) begin
                div_q <= div_d;
            end
            if (ce) begin
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                blank_q <= ~visible;
                x_q     <= x_d;
                y_q     <= y_d;
                fv_q    <= visible;
            end
        end
    end

`ifdef VGA_TIMING_LEAD_EN
    logic [LEAD-1:0] hs_sh_q, vs_sh_q, bl_sh_q, ls_sh_q, fs_sh_q;

    // Strobe stages hold levels; the one-clk pulse is re-formed on the ce that empties the last stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hs_sh_q <= {LEAD{~HS_POL}};
            vs_sh_q <= {LEAD{~VS_POL}};
            bl_sh_q <= {LEAD{1'b1}};
            ls_sh_q <= '0;
            fs_sh_q <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            ls_q <= ce && ls_sh_q[LEAD-1];
            fs_q <= ce && fs_sh_q[LEAD-1];
            if (ce) begin
                hs_sh_q <= (hs_sh_q << 1) | LEAD'(hs_q);
                vs_sh_q <= (vs_sh_q << 1) | LEAD'(vs_q);
                bl_sh_q <= (bl_sh_q << 1) | LEAD'(blank_q);
                ls_sh_q <= (ls_sh_q << 1) | LEAD'(h_first);
                fs_sh_q <= (fs_sh_q << 1) | LEAD'(h_first && v_first);
            end
        end
    end

    assign hs    = hs_sh_q[LEAD-1];
    assign vs    = vs_sh_q[LEAD-1];
    assign blank = bl_sh_q[LEAD-1];
`else
    localparam int unused_lead = LEAD;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            ls_q <= ce && h_first;
            fs_q <= ce && h_first && v_first;
        end
    end

    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

    assign pix_ce      = pix_ce_q;
    assign current_x   = x_q;
    assign current_y   = y_q;
    assign fetch_valid = fv_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule
